// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   A two-stage pipelined bitwise logic unit. A 3-bit key selects one of eight
//   bitwise functions, which is applied to operand A (x) and operand B. Operand B
//   is y, or the running accumulator when acc_mode is set. Both stages use
//   valid/ready handshakes. A counter records completed output handshakes.
//
//   Parameters
//     WIDTH  operand/result width in bits (>=1)
//     CNT_W  width of the completed-transaction counter (>=1)
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  input beat handshake
//     x, y, key            operands and function select (y unused in acc_mode)
//     acc_mode, acc_clr    accumulator as operand B / treat accumulator as 0
//     out_valid/out_ready  result handshake
//     r                    registered result
//     txn_cnt              completed output handshakes, wraps modulo 2^CNT_W
//     r_par                XOR-reduction of r (only with LOGIC_UNIT_PARITY_EN)
//
//   Optional feature macro: LOGIC_UNIT_PARITY_EN adds the r_par output.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       key,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [CNT_W-1:0] txn_cnt
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             r_par
`endif
);

  typedef enum logic [2:0] {
    FN_OR   = 3'd0,
    FN_NOR  = 3'd1,
    FN_AND  = 3'd2,
    FN_NAND = 3'd3,
    FN_XOR  = 3'd4,
    FN_XNOR = 3'd5,
    FN_PASS = 3'd6,
    FN_NOT  = 3'd7
  } fn_e;

  // Stage 1: captured beat
  logic             s1_valid_q,    s1_valid_d;
  logic [WIDTH-1:0] s1_x_q,        s1_x_d;
  logic [WIDTH-1:0] s1_y_q,        s1_y_d;
  fn_e              s1_key_q,      s1_key_d;
  logic             s1_acc_mode_q, s1_acc_mode_d;
  logic             s1_acc_clr_q,  s1_acc_clr_d;

  // Stage 2: result, accumulator, counter
  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] r_q,           r_d;
  logic [WIDTH-1:0] acc_q,         acc_d;
  logic [CNT_W-1:0] txn_cnt_q,     txn_cnt_d;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             r_par_q,       r_par_d;
`endif

  logic             s2_load;
  logic             accept;
  logic             out_hs;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] fn_res;

  // Stage 2 takes the stage-1 beat when the output register is empty or is
  // being drained this cycle; stage 1 can refill in the same cycle it empties.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Function evaluation on the stage-1 fields. The accumulator is only read
  // here, at s2_load, so it always reflects the preceding beat in the stream.
  always_comb begin
    op_b   = s1_acc_mode_q ? (s1_acc_clr_q ? '0 : acc_q) : s1_y_q;
    fn_res = s1_x_q;
    case (s1_key_q)
      FN_OR:   fn_res = s1_x_q | op_b;
      FN_NOR:  fn_res = ~(s1_x_q | op_b);
      FN_AND:  fn_res = s1_x_q & op_b;
      FN_NAND: fn_res = ~(s1_x_q & op_b);
      FN_XOR:  fn_res = s1_x_q ^ op_b;
      FN_XNOR: fn_res = ~(s1_x_q ^ op_b);
      FN_PASS: fn_res = s1_x_q;
      FN_NOT:  fn_res = ~s1_x_q;
    endcase
  end

  // NOTE: every signal driven in this block gets a hold value first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_x_d        = s1_x_q;
    s1_y_d        = s1_y_q;
    s1_key_d      = s1_key_q;
    s1_acc_mode_d = s1_acc_mode_q;
    s1_acc_clr_d  = s1_acc_clr_q;
    if (accept) begin
      s1_valid_d    = 1'b1;
      s1_x_d        = x;
      s1_y_d        = y;
      s1_key_d      = fn_e'(key);
      s1_acc_mode_d = acc_mode;
      s1_acc_clr_d  = acc_clr;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    acc_d       = acc_q;
    txn_cnt_d   = txn_cnt_q;
`ifdef LOGIC_UNIT_PARITY_EN
    r_par_d     = r_par_q;
`endif
    if (out_hs) begin
      txn_cnt_d   = txn_cnt_q + CNT_W'(1);
      out_valid_d = 1'b0;
    end
    // A load in the same cycle as a handshake refills the output register.
    if (s2_load) begin
      out_valid_d = 1'b1;
      r_d         = fn_res;
`ifdef LOGIC_UNIT_PARITY_EN
      r_par_d     = ^fn_res;
`endif
      if (s1_acc_mode_q) begin
        acc_d = fn_res;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset along with the valid bits; this keeps r
  // and the accumulator at 0 after reset and keeps X out of the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_key_q      <= FN_OR;
      s1_acc_mode_q <= 1'b0;
      s1_acc_clr_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      r_q           <= '0;
      acc_q         <= '0;
      txn_cnt_q     <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
      r_par_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_x_q        <= s1_x_d;
      s1_y_q        <= s1_y_d;
      s1_key_q      <= s1_key_d;
      s1_acc_mode_q <= s1_acc_mode_d;
      s1_acc_clr_q  <= s1_acc_clr_d;
      out_valid_q   <= out_valid_d;
      r_q           <= r_d;
      acc_q         <= acc_d;
      txn_cnt_q     <= txn_cnt_d;
`ifdef LOGIC_UNIT_PARITY_EN
      r_par_q       <= r_par_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign txn_cnt   = txn_cnt_q;
`ifdef LOGIC_UNIT_PARITY_EN
  assign r_par     = r_par_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Self-checking bench for logic_unit_pipe. A transaction-level reference
//   model (ordered queue of expected results plus a model accumulator and
//   counter) is updated at each accept/handshake; directed scenarios also use
//   constant expectation tables. Compile with LOGIC_UNIT_PARITY_EN to check
//   r_par as well.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic [2:0]       key = '0;
  logic             acc_mode = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] txn_cnt;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             r_par;
`endif

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .key       (key),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
`ifdef LOGIC_UNIT_PARITY_EN
    .txn_cnt   (txn_cnt),
    .r_par     (r_par)
`else
    .txn_cnt   (txn_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_acc = '0;
  int               m_cnt = 0;

  function automatic logic [WIDTH-1:0] ref_fn(input int k, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (k)
      0:       return a | b;
      1:       return ~(a | b);
      2:       return a & b;
      3:       return ~(a & b);
      4:       return a ^ b;
      5:       return ~(a ^ b);
      6:       return a;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
    logic [31:0] c;
    c = m_cnt;
    return c[CNT_W-1:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
  endtask

  // Called at the falling edge after that cycle's comparisons: updates the
  // model from the handshakes of this cycle, then advances to just past the
  // next rising edge where inputs may change.
  task automatic book();
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    if (in_valid && in_ready) begin
      b   = acc_mode ? (acc_clr ? '0 : m_acc) : y;
      res = ref_fn(int'(key), x, b);
      if (acc_mode) m_acc = res;
      exp_q.push_back(res);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [WIDTH-1:0] xx, input logic [WIDTH-1:0] yy,
                          input logic [2:0] k, input logic am, input logic ac);
    in_valid = v;
    x        = xx;
    y        = yy;
    key      = k;
    acc_mode = am;
    acc_clr  = ac;
  endtask

  task automatic test_reset();
    set_beat(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL reset_r got=%h exp=00", r); end
    n_chk++; if (txn_cnt !== '0) begin n_fail++; $display("FAIL reset_txn_cnt got=%0d exp=0", txn_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    book();
  endtask

  task automatic test_reset_midstream();
    bit seen;
    // Load acc with A5 and leave the result stalled at the output.
    out_ready = 1'b0;
    set_beat(1'b1, 8'hA5, 8'h00, 3'd0, 1'b1, 1'b1);
    @(negedge clk); book();
    in_valid = 1'b0;
    @(negedge clk); book();
    @(negedge clk); book();
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    n_chk++; if (r !== 8'hA5) begin n_fail++; $display("FAIL mid_pre_r got=%h exp=a5", r); end
    book();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL mid_rst_r got=%h exp=00", r); end
    n_chk++; if (txn_cnt !== '0) begin n_fail++; $display("FAIL mid_rst_txn_cnt got=%0d exp=0", txn_cnt); end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_in_ready got=%b exp=1", in_ready); end
    book();
    // OR with x=0 exposes the accumulator, which the reset must have cleared.
    out_ready = 1'b1;
    set_beat(1'b1, 8'h00, 8'hFF, 3'd0, 1'b1, 1'b0);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL mid_acc_cleared got=%h exp=00", r); end
      end
      book();
      in_valid = 1'b0;
    end
    if (!seen) begin n_chk++; n_fail++; $display("FAIL mid_acc_timeout got=none exp=result"); end
  endtask

  task automatic test_key_sweep();
    logic [WIDTH-1:0] tbl [8];
    bit exp_v;
    tbl = '{8'hFC, 8'h03, 8'hC0, 8'h3F, 8'h3C, 8'hC3, 8'hF0, 8'h0F};
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) set_beat(1'b1, 8'hF0, 8'hCC, 3'(c), 1'b0, 1'b0);
      else       in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) begin
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      exp_v = (c >= 2 && c < 10);
      n_chk++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL sweep_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); end
      if (exp_v) begin
        n_chk++; if (r !== tbl[c-2]) begin n_fail++; $display("FAIL sweep_r key=%0d got=%h exp=%h", c-2, r, tbl[c-2]); end
      end
      n_chk++; if (txn_cnt !== exp_cnt()) begin n_fail++; $display("FAIL sweep_txn_cnt got=%0d exp=%0d", txn_cnt, exp_cnt()); end
      book();
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] bx [4];
    logic [WIDTH-1:0] by [4];
    logic [2:0]       bk [4];
    int  accepts, drained;
    bit  acc_now, hs;
    for (int i = 0; i < 4; i++) begin
      bx[i] = WIDTH'($urandom);
      by[i] = WIDTH'($urandom);
      bk[i] = 3'($urandom_range(0, 7));
    end
    out_ready = 1'b0;
    accepts = 0;
    drained = 0;
    set_beat(1'b1, bx[0], by[0], bk[0], 1'b0, 1'b0);
    for (int c = 0; c < 40 && drained < 4; c++) begin
      if (c >= 6) out_ready = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        n_chk++; if (accepts != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", accepts); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        n_chk++; if (r !== ref_fn(int'(bk[0]), bx[0], by[0])) begin
          n_fail++; $display("FAIL bp_hold_r got=%h exp=%h", r, ref_fn(int'(bk[0]), bx[0], by[0]));
        end
      end
      if (out_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_spurious got=r=%h exp=no_result", r); end
        else if (r !== exp_q[0]) begin n_fail++; $display("FAIL bp_r got=%h exp=%h", r, exp_q[0]); end
      end
      n_chk++; if (txn_cnt !== exp_cnt()) begin n_fail++; $display("FAIL bp_txn_cnt got=%0d exp=%0d", txn_cnt, exp_cnt()); end
      acc_now = in_valid && in_ready;
      hs      = out_valid && out_ready;
      book();
      if (acc_now) begin
        accepts++;
        if (accepts < 4) set_beat(1'b1, bx[accepts], by[accepts], bk[accepts], 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
      if (hs) drained++;
    end
    n_chk++; if (drained != 4) begin n_fail++; $display("FAIL bp_drained got=%0d exp=4", drained); end
  endtask

  task automatic test_accumulator();
    logic [WIDTH-1:0] tx  [5];
    logic [WIDTH-1:0] ty  [5];
    logic [2:0]       tk  [5];
    logic             tam [5];
    logic             tac [5];
    logic [WIDTH-1:0] texp[5];
    int  sent, got;
    bit  acc_now;
    tx   = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
    ty   = '{WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 8'h55, WIDTH'($urandom)};
    tk   = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0};
    tam  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tac  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    texp = '{8'h01, 8'h03, 8'h00, 8'h55, 8'h00};
    out_ready = 1'b1;
    sent = 0;
    got  = 0;
    set_beat(1'b1, tx[0], ty[0], tk[0], tam[0], tac[0]);
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_chk++; if (r !== texp[got]) begin n_fail++; $display("FAIL acc_r beat=%0d got=%h exp=%h", got, r, texp[got]); end
        got++;
      end
      acc_now = in_valid && in_ready;
      book();
      if (acc_now) begin
        sent++;
        if (sent < 5) set_beat(1'b1, tx[sent], ty[sent], tk[sent], tam[sent], tac[sent]);
        else in_valid = 1'b0;
      end
    end
    n_chk++; if (got != 5) begin n_fail++; $display("FAIL acc_count got=%0d exp=5", got); end
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W-1:0] seq [5];
    int  sent, hs_n;
    bit  pend, acc_now;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
    out_ready = 1'b1;
    sent = 0;
    hs_n = 0;
    pend = 0;
    set_beat(1'b1, WIDTH'($urandom), WIDTH'($urandom), 3'd4, 1'b0, 1'b0);
    for (int c = 0; c < 14 && !(hs_n == 5 && !pend); c++) begin
      @(negedge clk);
      if (pend) begin
        n_chk++; if (txn_cnt !== seq[hs_n-1]) begin n_fail++; $display("FAIL wrap_txn_cnt n=%0d got=%0d exp=%0d", hs_n, txn_cnt, seq[hs_n-1]); end
        pend = 0;
      end
      if (out_valid && out_ready) begin hs_n++; pend = 1; end
      acc_now = in_valid && in_ready;
      book();
      if (acc_now) begin
        sent++;
        if (sent < 5) set_beat(1'b1, WIDTH'($urandom), WIDTH'($urandom), 3'd4, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    n_chk++; if (hs_n != 5) begin n_fail++; $display("FAIL wrap_handshakes got=%0d exp=5", hs_n); end
  endtask

`ifdef LOGIC_UNIT_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] px   [2];
    logic             pexp [2];
    int  got;
    bit  acc_now;
    px   = '{8'h07, 8'h03};
    pexp = '{1'b1, 1'b0};
    out_ready = 1'b1;
    got = 0;
    set_beat(1'b1, px[0], 8'h00, 3'd6, 1'b0, 1'b0);
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_chk++; if (r_par !== pexp[got]) begin n_fail++; $display("FAIL parity x=%h got=%b exp=%b", px[got], r_par, pexp[got]); end
        got++;
      end
      acc_now = in_valid && in_ready;
      book();
      if (acc_now) begin
        if (x == px[0]) set_beat(1'b1, px[1], 8'h00, 3'd6, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    n_chk++; if (got != 2) begin n_fail++; $display("FAIL parity_count got=%0d exp=2", got); end
  endtask
`endif

  task automatic new_random_beat();
    set_beat($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
  endtask

  task automatic test_random();
    bit acc_now;
    new_random_beat();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (out_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_spurious c=%0d got=r=%h exp=no_result", c, r); end
        else if (r !== exp_q[0]) begin n_fail++; $display("FAIL rand_r c=%0d got=%h exp=%h", c, r, exp_q[0]); end
`ifdef LOGIC_UNIT_PARITY_EN
        n_chk++;
        if (exp_q.size() > 0 && r_par !== ^exp_q[0]) begin n_fail++; $display("FAIL rand_par c=%0d got=%b exp=%b", c, r_par, ^exp_q[0]); end
`endif
      end
      n_chk++; if (txn_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rand_txn_cnt c=%0d got=%0d exp=%0d", c, txn_cnt, exp_cnt()); end
      acc_now = in_valid && in_ready;
      book();
      // A stalled source keeps presenting the same beat.
      if (acc_now || !in_valid) new_random_beat();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_chk++; if (r !== exp_q[0]) begin n_fail++; $display("FAIL drain_r got=%h exp=%h", r, exp_q[0]); end
      end
      book();
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_midstream();
    test_key_sweep();
    test_backpressure();
    test_accumulator();
    test_counter_wrap();
`ifdef LOGIC_UNIT_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the key-selected OR/NOR cell.
- Applies one of eight bitwise functions, chosen by a 3-bit key, to two WIDTH-bit operands.
- Two-stage pipeline with valid/ready handshakes, an optional running accumulator, and a completed-transaction counter.
- Sits between an operand source and a result sink in the datapath experiments.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of the transaction counter (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B; ignored when acc_mode=1.
- key  input  3  function select.
- acc_mode  input  1  use accumulator as operand B and write the result back to it.
- acc_clr  input  1  with acc_mode=1, treat the accumulator as 0 for this beat.
- out_valid  output  1  result present.
- out_ready  input  1  sink accepts result.
- r  output  WIDTH  result.
- txn_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (rst_n low, asynchronous, any time): s1_valid=0, out_valid=0, r=0, acc=0, txn_cnt=0. Beats in flight are discarded. in_ready=1 in the first cycle after release.
- Key map, with a = x and b = (acc_mode ? acc : y):
  - 0 OR, 1 NOR, 2 AND, 3 NAND, 4 XOR, 5 XNOR.
  - 6 PASS a, 7 NOT a (b unused).
- Stage 1 registers x, y, key, acc_mode, acc_clr and s1_valid.
- Stage 2 computes from those fields and registers r and out_valid.
- Flow control:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational).
  - Accept = in_valid && in_ready.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure. Throughput is 1 beat per cycle.
- When out_valid=1 and out_ready=0, r and out_valid hold. Stage 1 holds one beat; the input stalls when stage 1 is full.
- Output handshake (out_valid && out_ready): txn_cnt increments by 1, wrapping from 2^CNT_W-1 to 0. out_valid deasserts unless s2_load occurs in the same cycle.
- Accumulator:
  - acc is read and written only at s2_load, so it is always ordered with the beat stream.
  - Beats with acc_mode=1 write the result into acc.
  - Beats with acc_mode=0 leave acc unchanged.
  - acc_clr=1 with acc_mode=1 makes b=0 for that beat. acc_clr is ignored when acc_mode=0.
- A simultaneous accept, s2_load and output handshake in one cycle is legal. All three take effect.
- in_valid with in_ready=0 is not an accept. The source holds its data.
- All arithmetic is bitwise; no carries. r is exactly WIDTH bits.

Optional Feature:
- LOGIC_UNIT_PARITY_EN
- Defined:
  - Adds output r_par (1 bit), registered alongside r: the XOR-reduction of the stage-2 result, so r_par=1 for odd ones.
  - r_par follows the same hold/stall rules as r and resets to 0.
- Undefined: no r_par port exists; all other behaviour is identical.

Test Plan:
- Reset sweep: rst_n=0 mid-stream with out_valid=1 -> next sample shows out_valid=0, r=0, txn_cnt=0, acc=0. After release, in_ready=1.
- Key sweep, WIDTH=8, x=8'hF0, y=8'hCC, out_ready=1, keys 0..7 back-to-back -> r = FC,03,C0,3F,3C,C3,F0,0F. Each result appears 2 cycles after its accept, with no gaps.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready=0 after 2 accepts. r holds the first result. Releasing out_ready drains all 4 in order, and txn_cnt=4.
- Accumulator: beats (acc_mode=1, acc_clr=1, key=0, x=01) then (acc_mode=1, key=0, x=02) then (acc_mode=1, key=4, x=03) -> r=01, 03, 00. A following acc_mode=0 beat leaves acc=00.
- Counter wrap: CNT_W=2, 5 handshakes -> txn_cnt sequence 1,2,3,0,1.
- Parity (LOGIC_UNIT_PARITY_EN defined): key=6, x=8'h07 -> r_par=1; x=8'h03 -> r_par=0. The same bench compiled without the macro passes the key-sweep scenario unchanged.
